// File: rtl/spi_slave_sysclk_if.sv
// Pin and local byte-stream bundle for spi_slave_sysclk.
// slave is the responder's view; master is the view of the SPI master plus local logic.
interface spi_slave_sysclk_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  mosi;
  logic                  cs_n;
  logic                  miso;
  logic                  miso_oe;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  tx_underrun;
  logic                  frame_err;
  logic                  busy;

  modport slave (
    input  sclk, mosi, cs_n, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
  );

  modport master (
    output sclk, mosi, cs_n, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
  );
endinterface

// File: rtl/spi_slave_sysclk.sv
// Mode-0 SPI responder clocked only by clk: sclk/mosi/cs_n are oversampled and
// acted on via detected edges, with a one-entry tx holding register.
module spi_slave_sysclk #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_TX     = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_slave_sysclk_if.slave bus
);
  localparam int            SS       = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int            CW       = (DATA_WIDTH < 2) ? 1 : $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_e;

  // synchronizers plus one "previous" sample for edge detection
  logic [SS-1:0] sclk_sync_q, sclk_sync_d;
  logic [SS-1:0] cs_sync_q, cs_sync_d;
  logic [SS-1:0] mosi_sync_q, mosi_sync_d;
  logic          sclk_prev_q, sclk_prev_d;
  logic          cs_prev_q, cs_prev_d;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                  word_done_q, word_done_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  tx_ready_q, tx_ready_d;
  logic                  miso_q, miso_d;
  logic                  miso_oe_q, miso_oe_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_underrun_q, tx_underrun_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q, busy_d;

  logic                  sclk_s, cs_s, mosi_s;
  logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                  load;
  logic [DATA_WIDTH-1:0] load_word;
  logic [DATA_WIDTH-1:0] rx_word;

  assign sclk_s    = sclk_sync_q[SS-1];
  assign cs_s      = cs_sync_q[SS-1];
  assign mosi_s    = mosi_sync_q[SS-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  // an empty holding register at a word boundary means the idle pattern goes out
  assign load_word = tx_ready_q ? IDLE_TX : hold_q;
  assign rx_word   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SS-2:0], bus.sclk};
    cs_sync_d   = {cs_sync_q[SS-2:0], bus.cs_n};
    mosi_sync_d = {mosi_sync_q[SS-2:0], bus.mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    busy_d      = ~cs_s;
  end

  always_comb begin
    state_d       = state_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    word_done_d   = word_done_q;
    hold_d        = hold_q;
    tx_ready_d    = tx_ready_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    frame_err_d   = 1'b0;
    load          = 1'b0;

    // deselect outranks any sclk edge seen in the same cycle
    if (cs_rise) begin
      state_d     = ST_IDLE;
      miso_d      = 1'b0;
      miso_oe_d   = 1'b0;
      frame_err_d = (bit_cnt_q != '0);
      bit_cnt_d   = '0;
      word_done_d = 1'b0;
      rx_shift_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) begin
            load    = 1'b1;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          miso_d      = tx_shift_q[DATA_WIDTH-1];
          miso_oe_d   = 1'b1;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          state_d     = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            rx_shift_d = rx_word;
            if (bit_cnt_q == LAST_BIT) begin
              rx_data_d   = rx_word;
              rx_valid_d  = 1'b1;
              bit_cnt_d   = '0;
              word_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end else if (sclk_fall) begin
            if (word_done_q) begin
              load        = 1'b1;
              miso_d      = load_word[DATA_WIDTH-1];
              word_done_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
              miso_d     = tx_shift_q[DATA_WIDTH-2];
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (load) begin
      tx_shift_d    = load_word;
      tx_underrun_d = tx_ready_q;
    end

    // a same-cycle accept keeps the register full even while it is consumed
    if (bus.tx_valid && tx_ready_q) begin
      hold_d     = bus.tx_data;
      tx_ready_d = 1'b0;
    end else if (load && !tx_ready_q) begin
      tx_ready_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q   <= '0;
      cs_sync_q     <= '1;
      mosi_sync_q   <= '0;
      sclk_prev_q   <= 1'b0;
      cs_prev_q     <= 1'b1;
      state_q       <= ST_IDLE;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      word_done_q   <= 1'b0;
      hold_q        <= '0;
      tx_ready_q    <= 1'b1;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sclk_sync_q   <= sclk_sync_d;
      cs_sync_q     <= cs_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sclk_prev_q   <= sclk_prev_d;
      cs_prev_q     <= cs_prev_d;
      state_q       <= state_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      word_done_q   <= word_done_d;
      hold_q        <= hold_d;
      tx_ready_q    <= tx_ready_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.miso        = miso_q;
  assign bus.miso_oe     = miso_oe_q;
  assign bus.tx_ready    = tx_ready_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = tx_underrun_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_spi_slave_sysclk.sv
// Bench for spi_slave_sysclk: a behavioural mode-0 master plus scoreboard queues
// for the words the responder should receive and the words the master should see.
module tb_spi_slave_sysclk;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_slave_sysclk_if #(.DATA_WIDTH(8)) bus ();

  spi_slave_sysclk #(.DATA_WIDTH(8), .SYNC_STAGES(2), .IDLE_TX(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         vec = 0;
  int         miss = 0;
  int         ur_cnt = 0;
  int         fe_cnt = 0;
  int         ur_start = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] m_exp_q[$];
  logic [7:0] m_acc = 8'h00;
  logic [7:0] m_word = 8'h00;
  event       m_evt;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  // responder output monitor: every rx_valid pops one expected word
  task automatic rx_mon();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (bus.rx_valid) begin
        if (rx_exp_q.size() == 0) chk("rx_valid_unexpected", bus.rx_data, 8'hxx);
        else begin
          e = rx_exp_q.pop_front();
          chk("rx_data", bus.rx_data, e);
        end
      end
      if (bus.tx_underrun) ur_cnt++;
      if (bus.frame_err) fe_cnt++;
    end
  endtask

  // master-side monitor: each completed byte the master shifted in
  task automatic m_mon();
    logic [7:0] e;
    forever begin
      @(m_evt);
      if (m_exp_q.size() == 0) chk("miso_unexpected", m_word, 8'hxx);
      else begin
        e = m_exp_q.pop_front();
        chk("miso_word", m_word, e);
      end
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    for (int i = 0; i < 20 && !bus.tx_ready; i++) @(negedge clk);
    chk("tx_ready_before_push", 8'(bus.tx_ready), 8'h01);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic sbit(input logic b);
    bus.mosi = b;
    repeat (4) @(negedge clk);
    bus.sclk = 1'b1;
    m_acc = {m_acc[6:0], bus.miso};
    repeat (4) @(negedge clk);
    bus.sclk = 1'b0;
  endtask

  task automatic frame(input int nw, input logic [7:0] w0, input logic [7:0] w1,
                       input bit mid, input logic [7:0] mid_w,
                       input int gap, input bit nxt, input logic [7:0] nxt_w);
    int         ur0;
    logic [7:0] w;
    ur0 = ur_cnt;
    bus.cs_n = 1'b0;
    if (mid) push_tx(mid_w);
    repeat (8) @(negedge clk);
    ur_start = ur_cnt - ur0;
    for (int k = 0; k < nw; k++) begin
      w = (k == 0) ? w0 : w1;
      for (int b = 7; b >= 0; b--) sbit(w[b]);
      m_word = m_acc;
      ->m_evt;
    end
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b1;
    if (nxt) begin
      push_tx(nxt_w);
      repeat (gap - 1) @(negedge clk);
    end else begin
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miso"}, 8'(bus.miso), 8'h00);
    chk({tag, "_miso_oe"}, 8'(bus.miso_oe), 8'h00);
    chk({tag, "_tx_ready"}, 8'(bus.tx_ready), 8'h01);
    chk({tag, "_rx_data"}, bus.rx_data, 8'h00);
    chk({tag, "_rx_valid"}, 8'(bus.rx_valid), 8'h00);
    chk({tag, "_tx_underrun"}, 8'(bus.tx_underrun), 8'h00);
    chk({tag, "_frame_err"}, 8'(bus.frame_err), 8'h00);
    chk({tag, "_busy"}, 8'(bus.busy), 8'h00);
  endtask

  initial begin
    int fe0;
    bus.sclk = 1'b0; bus.mosi = 1'b0; bus.cs_n = 1'b1;
    bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
    fork
      rx_mon();
      m_mon();
    join_none

    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single word
    push_tx(8'h5A);
    chk("single_tx_ready_full", 8'(bus.tx_ready), 8'h00);
    rx_exp_q.push_back(8'h55); m_exp_q.push_back(8'h5A);
    fe0 = fe_cnt;
    frame(1, 8'h55, 8'h00, 1'b0, 8'h00, 8, 1'b0, 8'h00);
    chk("single_underrun_at_load", 8'(ur_start), 8'h00);
    chk("single_tx_ready_after", 8'(bus.tx_ready), 8'h01);
    chk("single_frame_err", 8'(fe_cnt - fe0), 8'h00);

    // two words under one cs_n, second tx word pushed after the first is taken
    push_tx(8'hA1);
    rx_exp_q.push_back(8'h33); rx_exp_q.push_back(8'hCC);
    m_exp_q.push_back(8'hA1);  m_exp_q.push_back(8'hB2);
    fe0 = fe_cnt;
    frame(2, 8'h33, 8'hCC, 1'b1, 8'hB2, 8, 1'b0, 8'h00);
    chk("multi_underrun_at_load", 8'(ur_start), 8'h00);
    chk("multi_frame_err", 8'(fe_cnt - fe0), 8'h00);

    // underrun
    rx_exp_q.push_back(8'hFF); m_exp_q.push_back(8'h00);
    frame(1, 8'hFF, 8'h00, 1'b0, 8'h00, 8, 1'b0, 8'h00);
    chk("underrun_at_load", 8'(ur_start), 8'h01);
    chk("underrun_rx_data", bus.rx_data, 8'hFF);

    // aborted after 5 rises
    fe0 = fe_cnt;
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < 5; b++) sbit(1'b0);
    repeat (4) @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_frame_err", 8'(fe_cnt - fe0), 8'h01);
    chk("abort_rx_data_kept", bus.rx_data, 8'hFF);
    chk("abort_miso_oe", 8'(bus.miso_oe), 8'h00);
    chk("abort_busy", 8'(bus.busy), 8'h00);
    push_tx(8'h11);
    rx_exp_q.push_back(8'h22); m_exp_q.push_back(8'h11);
    frame(1, 8'h22, 8'h00, 1'b0, 8'h00, 8, 1'b0, 8'h00);

    // reset in the middle of a word
    bus.cs_n = 1'b0;
    repeat (8) @(negedge clk);
    sbit(1'b1); sbit(1'b0); sbit(1'b0);
    chk("midrst_busy_before", 8'(bus.busy), 8'h01);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    bus.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    push_tx(8'h44);
    rx_exp_q.push_back(8'h88); m_exp_q.push_back(8'h44);
    frame(1, 8'h88, 8'h00, 1'b0, 8'h00, 8, 1'b0, 8'h00);

    // back-to-back frames, cs_n high for 4 clk between them
    fe0 = fe_cnt;
    push_tx(8'h11);
    rx_exp_q.push_back(8'h22); m_exp_q.push_back(8'h11);
    rx_exp_q.push_back(8'h88); m_exp_q.push_back(8'h44);
    frame(1, 8'h22, 8'h00, 1'b0, 8'h00, 4, 1'b1, 8'h44);
    frame(1, 8'h88, 8'h00, 1'b0, 8'h00, 8, 1'b0, 8'h00);
    chk("b2b_frame_err", 8'(fe_cnt - fe0), 8'h00);

    repeat (10) @(negedge clk);
    chk("rx_queue_drained", 8'(rx_exp_q.size()), 8'h00);
    chk("miso_queue_drained", 8'(m_exp_q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
